// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin tri-state bus arbiter.
// Holds the FSM state encoding and the width helper used by the top and the picker.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StGrant      = 2'd1,
        StTurnaround = 2'd2
    } arb_state_e;

    // Index width for n requesters; never zero so a 1-bit field always exists.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester searching upward from ptr_i, wrapping.
// Rotates the request vector by the pointer, applies fixed priority, then rotates back.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  idx_o
);

    localparam logic [ID_W:0] NReqW = (ID_W + 1)'(N_REQ);

    logic [N_REQ-1:0] rot;
    logic [ID_W-1:0]  first;
    logic [ID_W:0]    src;
    logic [ID_W:0]    sum;

    always_comb begin
        rot   = '0;
        first = '0;
        src   = '0;
        sum   = '0;

        // rot[i] is the requester i positions above the pointer.
        for (int i = 0; i < N_REQ; i++) begin
            src = {1'b0, ID_W'(i)} + {1'b0, ptr_i};
            if (src >= NReqW) begin
                src = src - NReqW;
            end
            rot[i] = eligible_i[src[ID_W-1:0]];
        end

        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = ID_W'(i);
            end
        end

        sum = {1'b0, first} + {1'b0, ptr_i};
        if (sum >= NReqW) begin
            sum = sum - NReqW;
        end

        valid_o = |eligible_i;
        idx_o   = sum[ID_W-1:0];
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter driving tri-state buffer enables, with turnaround gaps between
// owners and a hold limit that forces release and blocks the owner until it drops req.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned TA_CYCLES = 1,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req,
    output logic [N_REQ-1:0]              gnt,
    output logic [id_width(N_REQ)-1:0]    owner_id,
    output logic                          bus_busy,
    output logic                          timeout
);

    localparam int unsigned ID_W   = id_width(N_REQ);
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int unsigned TA_W   = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TA_W-1:0]  ta_q, ta_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic             release_bus;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .eligible_i (req & ~mask_q),
        .ptr_i      (ptr_q),
        .valid_o    (pick_valid),
        .idx_o      (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        ta_d        = ta_q;
        mask_d      = mask_q & req;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        release_bus = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // A voluntary drop wins over the hold limit: no timeout, no block.
                if (!req[owner_q]) begin
                    release_bus = 1'b1;
                end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
                    release_bus      = 1'b1;
                    timeout_d        = 1'b1;
                    mask_d[owner_q]  = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StTurnaround: begin
                if (ta_q == TA_W'(TA_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    ta_d = ta_q + TA_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (release_bus) begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
            ta_d    = '0;
            state_d = StTurnaround;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            hold_q    <= '0;
            ta_q      <= '0;
            mask_q    <= '0;
            gnt_q     <= '0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            ta_q      <= ta_d;
            mask_q    <= mask_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign bus_busy = busy_q;
    assign timeout  = timeout_q;

    // Contention guard on the tri-state enables.
    assert property (@(posedge clk) $onehot0(gnt_q));
    assert property (@(posedge clk) busy_q == (|gnt_q));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr (N_REQ=4, TA_CYCLES=1, MAX_HOLD=16).
// Expected outputs are queued with each stimulus step and popped after the clock edge.
module tb_bus_arbiter_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner_id;
    logic       bus_busy;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
        logic       to;
        bit         chk_owner;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .N_REQ     (4),
        .TA_CYCLES (1),
        .MAX_HOLD  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .owner_id (owner_id),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    function automatic logic [3:0] oh(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply rst/req for one edge and queue the outputs expected right after it.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic et);
        exp_t e;
        exp_t got;
        e.gnt       = eg;
        e.busy      = |eg;
        e.to        = et;
        e.owner     = 2'd0;
        e.chk_owner = r || (|eg);
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) e.owner = 2'(i);
        end
        rst = r;
        req = rq;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("gnt", gnt, got.gnt);
        check("bus_busy", {3'b0, bus_busy}, {3'b0, got.busy});
        check("timeout", {3'b0, timeout}, {3'b0, got.to});
        if (got.chk_owner) check("owner_id", {2'b0, owner_id}, {2'b0, got.owner});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requests high, then the first grant one edge later.
        cyc(1'b1, 4'b1111, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1111, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1111, oh(0), 1'b0);

        // Rotation 0,1,2,3,0: three grant cycles each, two idle cycles between owners.
        for (int o = 0; o < 4; o++) begin
            cyc(1'b0, 4'b1111, oh(o), 1'b0);
            cyc(1'b0, 4'b1111, oh(o), 1'b0);
            cyc(1'b0, 4'b1111 & ~oh(o), 4'b0000, 1'b0);
            cyc(1'b0, 4'b1111, 4'b0000, 1'b0);
            cyc(1'b0, 4'b1111, oh((o + 1) % 4), 1'b0);
        end
        repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Pointer wrap: owner 3 releases with req=0011, requester 0 must win.
        cyc(1'b0, 4'b1000, 4'b1000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0011, 4'b0001, 1'b0);
        repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Hold limit: exactly 16 grant cycles, one timeout pulse, then blocked.
        repeat (16) cyc(1'b0, 4'b0100, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b1);
        repeat (4) cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0);

        // Drop on the same cycle hold reaches 16: plain release, owner stays eligible.
        repeat (15) cyc(1'b0, 4'b0100, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0);
        repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset during GRANT: gnt drops at once, pointer back at 0 (1010 -> 0010).
        cyc(1'b0, 4'b0010, 4'b0010, 1'b0);
        cyc(1'b1, 4'b0010, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1010, 4'b0010, 1'b0);

        // Reset during TURNAROUND: no leftover gap, pointer back at 0.
        cyc(1'b0, 4'b1000, 4'b0000, 1'b0);
        cyc(1'b1, 4'b1010, 4'b0000, 1'b0);
        cyc(1'b0, 4'b1010, 4'b0010, 1'b0);
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
